fib_pair_serializer: RTL and testbench

//  Downstream stage for the double-rate Fibonacci generator. Accepts a pair of words per cycle
//  (num, num2) under a valid/ready handshake and buffers them in a small circular FIFO.

---
 rtl/fib_stream_pkg.sv | 20 ++
 rtl/fib_pair_serializer_if.sv | 44 ++++
 rtl/fib_recurrence_checker.sv | 61 ++++++
 rtl/fib_pair_serializer.sv | 89 ++++++++
 tb/tb_fib_pair_serializer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fib_stream_pkg.sv
// Shared types for the Fibonacci stream blocks: word type, default width, recurrence helper and
// the history states used by the recurrence checker.
package fib_stream_pkg;

  localparam int unsigned FIB_WIDTH = 16;

  typedef logic [FIB_WIDTH-1:0] fib_word_t;

  // How many popped words the checker has seen so far (saturates at two).
  typedef enum logic [1:0] {
    HistEmpty,
    HistOne,
    HistFull
  } hist_e;

  function automatic fib_word_t fib_next(fib_word_t a, fib_word_t b);
    return a + b;
  endfunction

endpackage

// File: rtl/fib_pair_serializer_if.sv
// Pair-in / word-out stream bundle between the double-rate generator, the serializer and a
// single-rate consumer. The slave modport is the serializer's view.
interface fib_pair_serializer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_num;
  logic [WIDTH-1:0] in_num2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_num;
  logic [CW-1:0]    count;
  logic             err;

  modport master (
    output in_valid,
    output in_num,
    output in_num2,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_num,
    input  count,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_num,
    input  in_num2,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_num,
    output count,
    output err
  );

endinterface

// File: rtl/fib_recurrence_checker.sv
// Watches the popped word stream and raises a sticky error when a word is not the sum of the
// two words popped before it (mod 2^WIDTH). Only the first two pops are exempt.
module fib_recurrence_checker
  import fib_stream_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pop,
  input  logic [WIDTH-1:0] word,
  output logic             err
);

  hist_e            hist_q, hist_d;
  logic [WIDTH-1:0] prev1_q, prev2_q;
  logic [WIDTH-1:0] sum;
  logic             err_q, err_d;

  if (WIDTH == FIB_WIDTH) begin : g_pkg_sum
    assign sum = fib_next(prev1_q, prev2_q);
  end else begin : g_local_sum
    assign sum = prev1_q + prev2_q;
  end

  always_comb begin
    hist_d = hist_q;
    err_d  = err_q;
    if (pop) begin
      unique case (hist_q)
        HistEmpty: hist_d = HistOne;
        HistOne:   hist_d = HistFull;
        HistFull: begin
          if (word != sum) begin
            err_d = 1'b1;
          end
        end
        default:   hist_d = HistEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= HistEmpty;
      err_q   <= 1'b0;
      prev1_q <= '0;
      prev2_q <= '0;
    end else begin
      hist_q <= hist_d;
      err_q  <= err_d;
      if (pop) begin
        prev2_q <= prev1_q;
        prev1_q <= word;
      end
    end
  end

  assign err = err_q;

endmodule

// File: rtl/fib_pair_serializer.sv
// Accepts a (num, num2) pair per cycle into a circular word FIFO and emits one word per cycle in
// order. Optional recurrence checker enabled by defining FIB_PAIR_SERIALIZER_CHECK_EN.
module fib_pair_serializer
  import fib_stream_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned DEPTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  fib_pair_serializer_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             in_ready, out_valid;
  logic             push, pop;

  // in_ready looks only at registered count, so there is no path from out_ready.
  always_comb begin
    in_ready  = !rst && ((DepthCnt - count_q) >= CW'(2));
    out_valid = !rst && (count_q != '0);
    push      = bus.in_valid && in_ready;
    pop       = out_valid && bus.out_ready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(2);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + (push ? CW'(2) : CW'(0)) - (pop ? CW'(1) : CW'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; out_num is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]          <= bus.in_num;
      mem_q[wr_ptr_q + PW'(1)] <= bus.in_num2;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_num   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.count     = count_q;

`ifdef FIB_PAIR_SERIALIZER_CHECK_EN
  fib_recurrence_checker #(
    .WIDTH (WIDTH)
  ) u_checker (
    .clk  (clk),
    .rst  (rst),
    .pop  (pop),
    .word (bus.out_num),
    .err  (bus.err)
  );
`else
  assign bus.err = 1'b0;
`endif

  count_le_depth_a : assert property (@(posedge clk) disable iff (rst) count_q <= DepthCnt);

  ptr_count_consistent_a : assert property (@(posedge clk) disable iff (rst)
    PW'(wr_ptr_q - rd_ptr_q) == count_q[PW-1:0]);

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Directed bench for fib_pair_serializer: scenario tasks with inline checks plus a per-cycle
// queue reference model for count, in_ready, out_valid and out_num.
module tb_fib_pair_serializer;

  localparam int unsigned W = 16;
  localparam int unsigned D = 8;

`ifdef FIB_PAIR_SERIALIZER_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fib_pair_serializer_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fib_pair_serializer #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] model_q [$];
  logic [W-1:0] got_q [$];

  // Reference model of the FIFO contents, advanced on every edge from the driven inputs.
  always @(posedge clk) begin
    bit m_push;
    bit m_pop;
    if (rst) begin
      model_q.delete();
    end else begin
      m_push = bus.in_valid && ((int'(D) - model_q.size()) >= 2);
      m_pop  = bus.out_ready && (model_q.size() != 0);
      if (m_pop) void'(model_q.pop_front());
      if (m_push) begin
        model_q.push_back(bus.in_num);
        model_q.push_back(bus.in_num2);
      end
    end
  end

  always @(negedge clk) begin
    int           n;
    logic         exp_rdy;
    logic         exp_vld;
    logic [W-1:0] exp_num;
    if (mon_en) begin
      n       = model_q.size();
      exp_rdy = !rst && ((int'(D) - n) >= 2);
      exp_vld = !rst && (n != 0);
      exp_num = exp_vld ? model_q[0] : '0;
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL mon_in_ready t=%0t: got %b want %b", $time, bus.in_ready, exp_rdy);
      end
      checks++;
      if (bus.out_valid !== exp_vld) begin
        errors++;
        $display("FAIL mon_out_valid t=%0t: got %b want %b", $time, bus.out_valid, exp_vld);
      end
      checks++;
      if (bus.out_num !== exp_num) begin
        errors++;
        $display("FAIL mon_out_num t=%0t: got %0d want %0d", $time, bus.out_num, exp_num);
      end
      checks++;
      if (bus.count !== 4'(n)) begin
        errors++;
        $display("FAIL mon_count t=%0t: got %0d want %0d", $time, bus.count, n);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got_q.push_back(bus.out_num);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 30 && model_q.size() != 0; n++) tick();
  endtask

  task automatic test_reset();
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.count !== 4'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", bus.count);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", bus.err);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [W-1:0] exp [4] = '{16'd1, 16'd1, 16'd2, 16'd3};
    got_q.delete();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_num    = 16'd1;
    bus.in_num2   = 16'd1;
    tick();
    bus.in_num  = 16'd2;
    bus.in_num2 = 16'd3;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_num !== 16'd1) begin
      errors++;
      $display("FAIL basic_first_word: got v=%b %0d want v=1 1", bus.out_valid, bus.out_num);
    end
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_num !== exp[i]) begin
        errors++;
        $display("FAIL basic_word%0d: got v=%b %0d want v=1 %0d", i, bus.out_valid,
                 bus.out_num, exp[i]);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_num !== 16'd0) begin
      errors++;
      $display("FAIL basic_empty: got v=%b %0d want v=0 0", bus.out_valid, bus.out_num);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL basic_err: got %b want 0", bus.err);
    end
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL basic_pop_count: got %0d want 4", got_q.size());
    end
    tick();
  endtask

  task automatic test_fill_and_almost_full();
    got_q.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_num   = 16'(10 + 2 * i);
      bus.in_num2  = 16'(11 + 2 * i);
      tick();
    end
    bus.in_num  = 16'd99;
    bus.in_num2 = 16'd99;
    @(negedge clk);
    checks++;
    if (bus.count !== 4'd8 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got count=%0d rdy=%b want count=8 rdy=0", bus.count,
               bus.in_ready);
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (bus.count !== 4'd8) begin
      errors++; $display("FAIL full_hold: got %0d want 8", bus.count);
    end
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.count !== 4'd7 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL one_free: got count=%0d rdy=%b want count=7 rdy=0", bus.count,
               bus.in_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.count !== 4'd7) begin
      errors++; $display("FAIL no_half_pair: got %0d want 7", bus.count);
    end
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.count !== 4'd6 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL two_free: got count=%0d rdy=%b want count=6 rdy=1", bus.count,
               bus.in_ready);
    end
    tick();
    drain();
    checks++;
    if (got_q.size() != 8) begin
      errors++; $display("FAIL fill_pop_count: got %0d want 8", got_q.size());
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== 16'(10 + i)) begin
        errors++; $display("FAIL fill_order%0d: got %0d want %0d", i, got_q[i], 10 + i);
      end
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] fib [20] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21,
                               16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610,
                               16'd987, 16'd1597, 16'd2584, 16'd4181, 16'd6765};
    int exp_cnt [8] = '{0, 2, 3, 4, 5, 6, 7, 6};
    int idx = 0;
    int cyc = 0;
    bit acc;
    got_q.delete();
    bus.out_ready = 1'b1;
    while (idx < 10 && cyc < 60) begin
      bus.in_valid = 1'b1;
      bus.in_num   = fib[2*idx];
      bus.in_num2  = fib[2*idx+1];
      @(negedge clk);
      if (cyc < 8) begin
        checks++;
        if (bus.count !== 4'(exp_cnt[cyc])) begin
          errors++;
          $display("FAIL stream_count%0d: got %0d want %0d", cyc, bus.count, exp_cnt[cyc]);
        end
      end
      acc = bus.in_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    checks++;
    if (idx != 10) begin
      errors++; $display("FAIL stream_timeout: got %0d pairs want 10", idx);
    end
    drain();
    checks++;
    if (got_q.size() != 20) begin
      errors++; $display("FAIL stream_pop_count: got %0d want 20", got_q.size());
    end
    for (int i = 0; i < 20 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== fib[i]) begin
        errors++; $display("FAIL stream_order%0d: got %0d want %0d", i, got_q[i], fib[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_num   = 16'(40 + 2 * i);
      bus.in_num2  = 16'(41 + 2 * i);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.count !== 4'd5) begin
      errors++; $display("FAIL mid_count5: got %0d want 5", bus.count);
    end
    tick();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_num   = 16'd50;
    bus.in_num2  = 16'd51;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_num !== 16'd0) begin
      errors++;
      $display("FAIL mid_in_reset: got rdy=%b v=%b num=%0d want 0 0 0", bus.in_ready,
               bus.out_valid, bus.out_num);
    end
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after_reset: got count=%0d v=%b rdy=%b want 0 0 1", bus.count,
               bus.out_valid, bus.in_ready);
    end
    tick();
    got_q.delete();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_num    = 16'd1;
    bus.in_num2   = 16'd1;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_num !== 16'd1) begin
      errors++;
      $display("FAIL mid_first_word: got v=%b %0d want v=1 1", bus.out_valid, bus.out_num);
    end
    tick();
    drain();
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL mid_pop_count: got %0d want 2", got_q.size());
    end
  endtask

  task automatic test_check();
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_num    = 16'd1;
    bus.in_num2   = 16'd1;
    tick();
    bus.in_num  = 16'd2;
    bus.in_num2 = 16'd4;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0) begin
        errors++; $display("FAIL chk_err_pop%0d: got %b want 0", k, bus.err);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.err !== ChkEn) begin
      errors++; $display("FAIL chk_err_set: got %b want %b", bus.err, ChkEn);
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (bus.err !== ChkEn) begin
      errors++; $display("FAIL chk_err_sticky: got %b want %b", bus.err, ChkEn);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL chk_err_cleared: got %b want 0", bus.err);
    end
    tick();
    got_q.delete();
    bus.in_valid = 1'b1;
    bus.in_num   = 16'd17711;
    bus.in_num2  = 16'd28657;
    tick();
    bus.in_num  = 16'd46368;
    bus.in_num2 = 16'd9489;
    tick();
    drain();
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL chk_wrap_err: got %b want 0", bus.err);
    end
    checks++;
    if (got_q.size() != 4 || got_q[got_q.size()-1] !== 16'd9489) begin
      errors++; $display("FAIL chk_wrap_words: got %0d words want 4 ending 9489", got_q.size());
    end
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_num    = '0;
    bus.in_num2   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_fill_and_almost_full();
    test_stream();
    test_reset_midstream();
    test_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
